axi_wr_rr_arbiter: RTL and testbench
====================================

Name: axi_wr_rr_arbiter

Overview:
- Round-robin master arbiter for the shared AXI write path (AW + W channels) of the interconnect.
- Replaces fixed lowest-index priority with a rotating pointer, so no master starves.
- Holds a grant from AW acceptance through the W beat carrying WLAST.
- Sits between the per-master AWVALID vector and the bus mux select; B routing stays ID-based and is outside this block.

Parameters:
- M_WIDTH, 2, log2 of master count; N = 2**M_WIDTH masters.
- MAX_OUTST, 4, outstanding-write limit; used only with the optional feature; legal range 1..255.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m_awvalid  in  N  per-master AWVALID request vector
- bus_awvalid  in  1  muxed AWVALID on the bus
- bus_awready  in  1  slave-side AWREADY
- bus_wvalid  in  1  muxed WVALID
- bus_wready  in  1  slave-side WREADY
- bus_wlast  in  1  muxed WLAST
- bus_bvalid  in  1  BVALID at the bus
- bus_bready  in  1  BREADY at the bus
- grant_sel  out  M_WIDTH  registered master select for the AW/W muxes
- grant_valid  out  1  grant_sel is meaningful; the mux gates VALID/READY with it
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs go to 0. State = IDLE, rr_ptr = N-1 (master 0 wins first), internal flags cleared. Reset mid-burst aborts immediately; there is no drain.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Search m_awvalid starting at index rr_ptr+1 mod N, wrapping.
  - First set bit wins: grant_sel <= winner, go to ADDR.
  - Arbitration latency is 1 cycle from request to grant_valid.
  - No request: stay in IDLE; grant_sel holds its last value.
- ADDR:
  - grant_valid = 1.
  - A W handshake may precede AW. On bus_wvalid & bus_wready & bus_wlast, set wlast_seen.
  - On bus_awvalid & bus_awready: if wlast_seen is set, or WLAST handshakes in the same cycle, go to IDLE; otherwise go to DATA.
- DATA:
  - grant_valid = 1.
  - On bus_wvalid & bus_wready & bus_wlast, go to IDLE.
- Leaving ADDR or DATA toward IDLE: rr_ptr <= grant_sel, clear wlast_seen. Grant ends on the cycle after the last handshake; minimum gap between bursts is 1 IDLE cycle.
- grant_sel is stable from entering ADDR until IDLE, independent of m_awvalid changes. If the granted master drops AWVALID (protocol violation), the block still waits.
- grant_valid = (state == ADDR) || (state == DATA); busy is the same term.
- Single-master case (only one bit ever set): that master is re-granted after every 1-cycle IDLE.
- rr_ptr arithmetic is modulo N and wraps from N-1 to 0.

Optional Feature:
- Macro: AXI_WR_OUTST_LIMIT_EN.
- Defined:
  - 8-bit outst_cnt: +1 on AW handshake, -1 on bus_bvalid & bus_bready.
  - Simultaneous increment and decrement leaves it unchanged.
  - In IDLE, no grant is issued while outst_cnt == MAX_OUTST. The search resumes the cycle after the count drops.
  - Reset value 0. A decrement at 0 saturates at 0.
- Not defined: no counter; bus_bvalid and bus_bready are unused; grants are never throttled.

Decomposition:
- Package axi_arb_pkg:
  - wr_arb_state_t enum {IDLE, ADDR, DATA}
  - localparam-style function n_masters(M_WIDTH)
- Sub-module rr_pick (combinational, parameter M_WIDTH):
  - Inputs: req vector, ptr.
  - Outputs: any, idx.
  - Reusable by a future read-address RR arbiter.

Test Plan:
- Reset, then m_awvalid = 4'b1111 with 2-beat bursts: grants follow 0,1,2,3,0, each 1 cycle after the preceding IDLE.
- rr_ptr = 1, m_awvalid = 4'b1001: grant 3. Next burst, with 4'b1001 held: grant 0 (wrap).
- Hold bus_wready = 0 for 5 cycles in DATA while m_awvalid changes to 4'b0110: grant_sel unchanged, grant_valid = 1, until WLAST.
- Single-beat WLAST handshake in the same cycle as AW: ADDR -> IDLE directly, DATA never entered. W-before-AW case: wlast_seen is set and AW acceptance returns to IDLE.
- rstn low during DATA: all outputs 0 asynchronously. After release with m_awvalid = 4'b0100: grant 2.
- With AXI_WR_OUTST_LIMIT_EN, MAX_OUTST = 2: two AW accepted with no B → third request waits in IDLE. One B handshake → grant on the following cycle.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write-path round-robin arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_arb_state_t;

  function automatic int n_masters(input int m_width);
    return 32'sd1 << m_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int M_WIDTH = 2
) (
  input  logic [n_masters(M_WIDTH)-1:0] req,
  input  logic [M_WIDTH-1:0]            ptr,
  output logic                          any,
  output logic [M_WIDTH-1:0]            idx
);

  localparam int N = n_masters(M_WIDTH);

  logic [M_WIDTH-1:0] cand_s;
  logic               hit_s;

  // Walk ptr+1 .. ptr+N; the last candidate is ptr itself so a lone requester always wins
  always_comb begin
    any    = 1'b0;
    idx    = ptr;
    cand_s = ptr;
    hit_s  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s = ptr + M_WIDTH'(i);
      hit_s  = req[cand_s] & ~any;
      any    = any | hit_s;
      idx    = hit_s ? cand_s : idx;
    end
  end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin grant for the shared AXI AW/W path; grant held from AW through WLAST.
// Optional outstanding-write throttle enabled by defining AXI_WR_OUTST_LIMIT_EN.
module axi_wr_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int M_WIDTH   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [n_masters(M_WIDTH)-1:0] m_awvalid,
  input  logic                          bus_awvalid,
  input  logic                          bus_awready,
  input  logic                          bus_wvalid,
  input  logic                          bus_wready,
  input  logic                          bus_wlast,
  input  logic                          bus_bvalid,
  input  logic                          bus_bready,
  output logic [M_WIDTH-1:0]            grant_sel,
  output logic                          grant_valid,
  output logic                          busy
);

  wr_arb_state_t      state_q, state_d;
  logic [M_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [M_WIDTH-1:0] grant_sel_q, grant_sel_d;
  logic               wlast_seen_q, wlast_seen_d;
  logic               grant_valid_q, grant_valid_d;
  logic               busy_q, busy_d;
  logic               pick_any_s;
  logic [M_WIDTH-1:0] pick_idx_s;
  logic               may_grant_s;
  logic               aw_hs_s;
  logic               w_last_hs_s;

  assign aw_hs_s     = bus_awvalid & bus_awready;
  assign w_last_hs_s = bus_wvalid & bus_wready & bus_wlast;

  rr_pick #(.M_WIDTH(M_WIDTH)) u_pick (
    .req (m_awvalid),
    .ptr (rr_ptr_q),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

`ifdef AXI_WR_OUTST_LIMIT_EN
  logic [7:0] outst_cnt_q, outst_cnt_d;
  logic       b_hs_s;

  assign b_hs_s      = bus_bvalid & bus_bready;
  assign may_grant_s = (outst_cnt_q != 8'(MAX_OUTST));

  // Outstanding count: simultaneous AW and B cancel, decrement floors at zero
  always_comb begin
    if (aw_hs_s && !b_hs_s) begin
      outst_cnt_d = outst_cnt_q + 8'd1;
    end else if (!aw_hs_s && b_hs_s && (outst_cnt_q != 8'd0)) begin
      outst_cnt_d = outst_cnt_q - 8'd1;
    end else begin
      outst_cnt_d = outst_cnt_q;
    end
  end

  // Outstanding count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_cnt_q <= 8'd0;
    end else begin
      outst_cnt_q <= outst_cnt_d;
    end
  end
`else
  logic unused_b_s;

  assign may_grant_s = 1'b1;
  assign unused_b_s  = bus_bvalid ^ bus_bready ^ (MAX_OUTST == 32'sd0);
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= {M_WIDTH{1'b1}};
      grant_sel_q   <= {M_WIDTH{1'b0}};
      wlast_seen_q  <= 1'b0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_sel_q   <= grant_sel_d;
      wlast_seen_q  <= wlast_seen_d;
      grant_valid_q <= grant_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next state; WLAST may handshake before, with, or after the AW handshake
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_sel_d  = grant_sel_q;
    wlast_seen_d = wlast_seen_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s && may_grant_s) begin
          state_d     = ADDR;
          grant_sel_d = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (aw_hs_s && (wlast_seen_q || w_last_hs_s)) begin
          state_d      = IDLE;
          rr_ptr_d     = grant_sel_q;
          wlast_seen_d = 1'b0;
        end else if (aw_hs_s) begin
          state_d = DATA;
        end else if (w_last_hs_s) begin
          wlast_seen_d = 1'b1;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (w_last_hs_s) begin
          state_d      = IDLE;
          rr_ptr_d     = grant_sel_q;
          wlast_seen_d = 1'b0;
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d      = IDLE;
        wlast_seen_d = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_comb begin
    grant_valid_d = (state_d == ADDR) || (state_d == DATA);
    busy_d        = (state_d != IDLE);
  end

  assign grant_sel   = grant_sel_q;
  assign grant_valid = grant_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Scoreboard bench for axi_wr_rr_arbiter: expected grants queued by stimulus, checked by a monitor.
module tb_axi_wr_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] m_awvalid = 4'b0000;
  logic       bus_awvalid = 1'b0;
  logic       bus_awready = 1'b0;
  logic       bus_wvalid = 1'b0;
  logic       bus_wready = 1'b0;
  logic       bus_wlast = 1'b0;
  logic       bus_bvalid = 1'b0;
  logic       bus_bready = 1'b0;
  logic [1:0] grant_sel;
  logic       grant_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int sb_q[$];
  logic gv_prev = 1'b0;

  axi_wr_rr_arbiter #(.M_WIDTH(2), .MAX_OUTST(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m_awvalid   (m_awvalid),
    .bus_awvalid (bus_awvalid),
    .bus_awready (bus_awready),
    .bus_wvalid  (bus_wvalid),
    .bus_wready  (bus_wready),
    .bus_wlast   (bus_wlast),
    .bus_bvalid  (bus_bvalid),
    .bus_bready  (bus_bready),
    .grant_sel   (grant_sel),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller leaves the DUT idle with requests applied; grant must appear after one edge.
  task automatic grant_expect(input int exp_sel);
    sb_q.push_back(exp_sel);
    tick();
    chk("grant_latency", grant_valid, 1);
  endtask

  task automatic aw_only();
    bus_awvalid = 1'b1; bus_awready = 1'b1;
    tick();
    bus_awvalid = 1'b0; bus_awready = 1'b0;
  endtask

  task automatic w_beat(input logic last);
    bus_wvalid = 1'b1; bus_wready = 1'b1; bus_wlast = last;
    tick();
    bus_wvalid = 1'b0; bus_wready = 1'b0; bus_wlast = 1'b0;
  endtask

  task automatic aw_w_last();
    bus_awvalid = 1'b1; bus_awready = 1'b1;
    bus_wvalid = 1'b1; bus_wready = 1'b1; bus_wlast = 1'b1;
    tick();
    bus_awvalid = 1'b0; bus_awready = 1'b0;
    bus_wvalid = 1'b0; bus_wready = 1'b0; bus_wlast = 1'b0;
  endtask

  task automatic burst2();
    aw_only();
    w_beat(1'b0);
    w_beat(1'b1);
    chk("idle_gap", grant_valid, 0);
  endtask

  // Monitor: every new grant is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (!rstn) begin
      gv_prev <= 1'b0;
    end else begin
      if (grant_valid && !gv_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_grant: got grant_sel=%0d, expected no grant at %0t", grant_sel, $time);
        end else begin
          chk("sb_grant_sel", grant_sel, sb_q.pop_front());
        end
      end
      gv_prev <= grant_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) tick();
    chk("reset_grant_valid", grant_valid, 0);
    chk("reset_grant_sel", grant_sel, 0);
    chk("reset_busy", busy, 0);
    rstn = 1'b1;
    tick();

    // All masters requesting: 0,1,2,3,0
    m_awvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      grant_expect(k % 4);
      burst2();
    end

    // Bring rr_ptr to 1, then 1001 gives 3 and wraps to 0
    m_awvalid = 4'b0010;
    grant_expect(1);
    burst2();
    m_awvalid = 4'b1001;
    grant_expect(3);
    burst2();
    grant_expect(0);
    burst2();

    // W stalled in DATA while requests change: grant frozen
    grant_expect(3);
    aw_only();
    m_awvalid  = 4'b0110;
    bus_wvalid = 1'b1; bus_wready = 1'b0; bus_wlast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_grant_valid", grant_valid, 1);
      chk("stall_grant_sel", grant_sel, 3);
    end
    bus_wready = 1'b1;
    tick();
    bus_wvalid = 1'b0; bus_wready = 1'b0; bus_wlast = 1'b0;
    chk("stall_release", grant_valid, 0);

    // Single-beat AW+WLAST together: straight back to IDLE
    grant_expect(1);
    aw_w_last();
    chk("same_cycle_grant_valid", grant_valid, 0);
    chk("same_cycle_busy", busy, 0);

    // WLAST before AW: grant held until AW
    grant_expect(2);
    w_beat(1'b1);
    chk("w_first_hold", grant_valid, 1);
    aw_only();
    chk("w_first_done", grant_valid, 0);

    // Asynchronous reset in DATA
    grant_expect(1);
    aw_only();
    chk("data_busy", busy, 1);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_grant_valid", grant_valid, 0);
    chk("async_rst_grant_sel", grant_sel, 0);
    chk("async_rst_busy", busy, 0);
    m_awvalid = 4'b0100;
    tick();
    rstn = 1'b1;
    grant_expect(2);
    burst2();
    m_awvalid = 4'b0000;
    tick();

`ifdef AXI_WR_OUTST_LIMIT_EN
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_awvalid = 4'b0001;
    grant_expect(0);
    aw_w_last();
    grant_expect(0);
    aw_w_last();
    tick();
    chk("limit_hold_a", grant_valid, 0);
    tick();
    chk("limit_hold_b", grant_valid, 0);
    bus_bvalid = 1'b1; bus_bready = 1'b1;
    tick();
    bus_bvalid = 1'b0; bus_bready = 1'b0;
    chk("limit_b_cycle", grant_valid, 0);
    grant_expect(0);
    aw_w_last();
    m_awvalid = 4'b0000;
    tick();
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
